// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_pkg
// Brief    : Shared types and defaults for the weighted burst scheduler.
// Revision : 1.0
// ============================================================================
package arb_pkg;

    localparam int ARB_NUM_PORTS = 8;
    localparam int ARB_PORT_W    = 3;
    localparam int ARB_WEIGHT_W  = 4;

    localparam logic ARB_SCHEME_RR  = 1'b0;
    localparam logic ARB_SCHEME_WRR = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : arb_rr_pick
// Brief    : Combinational rotating-priority pick: first set req bit at or after base.
// Revision : 1.0
// ============================================================================
module arb_rr_pick #(
    parameter int NUM_PORTS = 8,
    parameter int PORT_W    = 3
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    base,
    output logic                 found,
    output logic [PORT_W-1:0]    idx
);

    logic [2*NUM_PORTS-1:0] req_dbl;
    logic [NUM_PORTS-1:0]   rotated;
    logic [PORT_W-1:0]      offset;

    // Doubling the vector makes a rotate-right a plain part-select.
    assign req_dbl = {req, req};
    assign rotated = req_dbl[base +: NUM_PORTS];

    always_comb begin
        found  = 1'b0;
        offset = '0;
        // Descending scan so the lowest set offset is the last one written.
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                found  = 1'b1;
                offset = PORT_W'(k);
            end
        end
    end

    assign idx = base + offset;

endmodule
`default_nettype wire

// File: rtl/arb_burst_sched.sv
`default_nettype none
// ============================================================================
// Module   : arb_burst_sched
// Brief    : Weighted round-robin burst scheduler with grant-beat-release FSM.
// Revision : 1.0
// ============================================================================
module arb_burst_sched
    import arb_pkg::*;
#(
    parameter int NUM_PORTS = ARB_NUM_PORTS,
    parameter int PORT_W    = ARB_PORT_W,
    parameter int WEIGHT_W  = ARB_WEIGHT_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          port_req,
    input  logic                          cfg_arb_scheme,
    input  logic [NUM_PORTS*WEIGHT_W-1:0] cfg_weight,
    input  logic                          beat_done,
    output logic                          gnt_valid,
    output logic [PORT_W-1:0]             gnt_port,
    output logic [NUM_PORTS-1:0]          gnt_onehot,
    output logic [PORT_W-1:0]             high_priority,
    output logic [WEIGHT_W-1:0]           credit
);

    arb_state_t            state, state_nxt;
    logic                  valid_nxt;
    logic [PORT_W-1:0]     port_nxt;
    logic [NUM_PORTS-1:0]  onehot_nxt;
    logic [PORT_W-1:0]     hp_nxt;
    logic [WEIGHT_W-1:0]   credit_nxt;
    logic                  end_burst;

    logic                  pick_found;
    logic [PORT_W-1:0]     pick_idx;
    logic [WEIGHT_W-1:0]   weights [NUM_PORTS];
    logic [WEIGHT_W-1:0]   pick_weight;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_weight
        assign weights[i] = cfg_weight[i*WEIGHT_W +: WEIGHT_W];
    end

    assign pick_weight = weights[pick_idx];

    arb_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_pick (
        .req   (port_req),
        .base  (high_priority),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            gnt_valid     <= 1'b0;
            gnt_port      <= '0;
            gnt_onehot    <= '0;
            high_priority <= '0;
            credit        <= '0;
        end else begin
            state         <= state_nxt;
            gnt_valid     <= valid_nxt;
            gnt_port      <= port_nxt;
            gnt_onehot    <= onehot_nxt;
            high_priority <= hp_nxt;
            credit        <= credit_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        valid_nxt  = gnt_valid;
        port_nxt   = gnt_port;
        onehot_nxt = gnt_onehot;
        hp_nxt     = high_priority;
        credit_nxt = credit;
        end_burst  = 1'b0;

        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt  = GRANT;
                    valid_nxt  = 1'b1;
                    port_nxt   = pick_idx;
                    onehot_nxt = NUM_PORTS'(1) << pick_idx;
                    if (cfg_arb_scheme == ARB_SCHEME_WRR)
                        credit_nxt = (pick_weight == '0) ? WEIGHT_W'(1) : pick_weight;
                    else
                        credit_nxt = WEIGHT_W'(1);
                end
            end
            GRANT: begin
                // A beat coinciding with a request drop is counted; the grant ends once.
                if (beat_done) begin
                    if (credit == WEIGHT_W'(1))
                        end_burst = 1'b1;
                    else
                        credit_nxt = credit - WEIGHT_W'(1);
                end
                if (!port_req[gnt_port])
                    end_burst = 1'b1;
                if (end_burst) begin
                    state_nxt  = RELEASE;
                    valid_nxt  = 1'b0;
                    port_nxt   = '0;
                    onehot_nxt = '0;
                    credit_nxt = '0;
                    hp_nxt     = gnt_port + PORT_W'(1);
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt  = IDLE;
                valid_nxt  = 1'b0;
                port_nxt   = '0;
                onehot_nxt = '0;
                credit_nxt = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_arb_burst_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_arb_burst_sched
// Brief    : Self-checking bench for arb_burst_sched against a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_arb_burst_sched;

    localparam int N  = 8;
    localparam int WW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  port_req;
    logic          cfg_arb_scheme;
    logic [N*WW-1:0] cfg_weight;
    logic          beat_done;
    logic          gnt_valid;
    logic [2:0]    gnt_port;
    logic [N-1:0]  gnt_onehot;
    logic [2:0]    high_priority;
    logic [WW-1:0] credit;

    int checks = 0;
    int errors = 0;

    // Reference: a grant is "busy" with a number of beats left; after a grant
    // ends there is one dead cycle before a new decision may be taken.
    bit m_busy;
    int m_port;
    int m_left;
    int m_gap;
    int m_hp;

    arb_burst_sched dut (
        .clk            (clk),
        .reset          (reset),
        .port_req       (port_req),
        .cfg_arb_scheme (cfg_arb_scheme),
        .cfg_weight     (cfg_weight),
        .beat_done      (beat_done),
        .gnt_valid      (gnt_valid),
        .gnt_port       (gnt_port),
        .gnt_onehot     (gnt_onehot),
        .high_priority  (high_priority),
        .credit         (credit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_weight(input int p, input int w);
        cfg_weight[p*WW +: WW] = WW'(w);
    endtask

    task automatic model_edge();
        int w;
        int p;
        if (reset) begin
            m_busy = 0; m_port = 0; m_left = 0; m_gap = 0; m_hp = 0;
        end else if (m_busy) begin
            if (beat_done) m_left = m_left - 1;
            if (m_left == 0 || !port_req[m_port]) begin
                m_busy = 0;
                m_hp   = (m_port + 1) % N;
                m_gap  = 1;
                m_left = 0;
            end
        end else if (m_gap > 0) begin
            m_gap = m_gap - 1;
        end else if (port_req != 0) begin
            for (int k = 0; k < N; k++) begin
                p = (m_hp + k) % N;
                if (port_req[p] && !m_busy) begin
                    m_busy = 1;
                    m_port = p;
                end
            end
            w = int'((cfg_weight >> (m_port * WW)) & 32'hF);
            m_left = cfg_arb_scheme ? ((w == 0) ? 1 : w) : 1;
        end
    endtask

    task automatic check_all();
        check("gnt_valid",     {31'b0, gnt_valid},     {31'b0, m_busy});
        check("gnt_port",      {29'b0, gnt_port},      m_busy ? m_port : 0);
        check("gnt_onehot",    {24'b0, gnt_onehot},    m_busy ? (32'd1 << m_port) : 32'd0);
        check("high_priority", {29'b0, high_priority}, m_hp);
        check("credit",        {28'b0, credit},        m_busy ? m_left : 0);
    endtask

    task automatic step(input logic rst_in, input logic [N-1:0] req, input logic beat);
        reset     = rst_in;
        port_req  = req;
        beat_done = beat;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        reset = 1'b1; port_req = '0; beat_done = 1'b0;
        cfg_arb_scheme = 1'b0; cfg_weight = '0;

        // Reset and idle
        step(1, 8'h00, 0);
        step(1, 8'h00, 0);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 0);

        // Plain round-robin between ports 0 and 7
        for (int i = 0; i < 14; i++) step(0, 8'h81, 1);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 0);

        // Weighted burst on port 3, weight 4
        cfg_arb_scheme = 1'b1;
        set_weight(3, 4); set_weight(5, 0); set_weight(2, 6); set_weight(1, 5);
        step(0, 8'h08, 1);
        check("w4_credit_first", {28'b0, credit}, 32'd4);
        for (int i = 0; i < 4; i++) step(0, 8'h08, 1);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 0);
        check("w4_hp_after", {29'b0, high_priority}, 32'd4);

        // Zero weight on port 5 acts as one beat
        for (int i = 0; i < 4; i++) step(0, 8'h20, 1);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 0);

        // Port 2, weight 6: request dropped together with the 2nd beat
        step(0, 8'h04, 0);
        check("p2_grant", {29'b0, gnt_port}, 32'd2);
        step(0, 8'h04, 1);
        step(0, 8'h00, 1);
        check("p2_drop_valid", {31'b0, gnt_valid}, 32'd0);
        check("p2_drop_hp", {29'b0, high_priority}, 32'd3);
        for (int i = 0; i < 3; i++) step(0, 8'h42, 0);
        check("wrap_pick", {29'b0, gnt_port}, 32'd6);
        step(0, 8'h00, 0);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 0);

        // Reset in the middle of a 5-beat burst on port 1
        step(0, 8'h02, 1);
        step(0, 8'h02, 1);
        step(0, 8'h02, 1);
        step(1, 8'h02, 1);
        check("rst_mid_valid", {31'b0, gnt_valid}, 32'd0);
        check("rst_mid_credit", {28'b0, credit}, 32'd0);
        step(0, 8'h02, 0);
        check("rst_fresh_credit", {28'b0, credit}, 32'd5);
        for (int i = 0; i < 8; i++) step(0, 8'h02, 1);

        // Randomized traffic, including mid-burst config changes
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) cfg_arb_scheme = 1'($urandom);
            if ($urandom_range(0, 7) == 0) cfg_weight = $urandom;
            step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) == 0) ? N'($urandom) : port_req,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arb_burst_sched.md
# arb_burst_sched

Weighted round-robin burst scheduler for the 8-port shared resource. Sits between the port requesters and the shared datapath: it picks one requesting port by rotating priority and holds the grant for a configurable number of transfer beats. It then rotates priority past the winner. It replaces single-shot grant/ack arbitration with a self-contained grant–beat–release sequence.

## Interface
- NUM_PORTS, 8: number of requesting ports; power of two.
- PORT_W, 3: log2(NUM_PORTS); width of port indices.
- WEIGHT_W, 4: width of each per-port burst weight.

- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- port_req  in  NUM_PORTS  level request per port; bit i = port i.
- cfg_arb_scheme  in  1  0 = plain round-robin, one beat per grant; 1 = weighted burst.
- cfg_weight  in  NUM_PORTS*WEIGHT_W  burst weight for port i in bits [i*WEIGHT_W +: WEIGHT_W].
- beat_done  in  1  granted port completed one transfer beat this cycle.
- gnt_valid  out  1  grant active.
- gnt_port  out  PORT_W  index of granted port; 0 when gnt_valid=0.
- gnt_onehot  out  NUM_PORTS  one-hot of gnt_port when gnt_valid=1, else 0.
- high_priority  out  PORT_W  port currently holding top priority.
- credit  out  WEIGHT_W  beats remaining in the current burst; 0 outside GRANT.

## Operation
- FSM states: IDLE, GRANT, RELEASE. All outputs are registered.
- IDLE behaviour:
  - If port_req==0, stay in IDLE.
  - Otherwise pick the first set bit scanning high_priority, high_priority+1, … modulo NUM_PORTS; 7 wraps to 0.
  - Register the winner into gnt_port and set gnt_valid=1.
  - Load credit with 1 if cfg_arb_scheme=0. If cfg_arb_scheme=1, load the winner's weight, with weight 0 treated as 1.
  - Go to GRANT.
- GRANT behaviour:
  - gnt_port, gnt_onehot and gnt_valid are stable.
  - Each beat_done decrements credit.
  - Exit when beat_done arrives with credit==1, or when port_req[gnt_port]==0, whichever comes first.
  - If both occur in the same cycle, the beat is counted and the grant ends once.
  - On exit: gnt_valid<=0, gnt_port<=0, credit<=0, high_priority<=gnt_port+1 (mod NUM_PORTS), state<=RELEASE.
- RELEASE behaviour: one dead (turnaround) cycle with gnt_valid=0, then IDLE unconditionally.
- Input handling:
  - beat_done outside GRANT is ignored.
  - cfg_weight and cfg_arb_scheme are sampled only at the IDLE→GRANT decision. Changes mid-burst do not affect the active burst.
- high_priority changes only on grant exit. A requester that is never granted never moves priority.
- Reset values: state=IDLE, gnt_valid=0, gnt_port=0, gnt_onehot=0, high_priority=0, credit=0.
- Reset asserted mid-burst aborts the grant. gnt_valid is 0 in the cycle after the reset edge.

## Timing
- Request-to-grant latency: gnt_valid rises 1 cycle after port_req is first sampled nonzero in IDLE.
- Grant end: gnt_valid falls on the edge after the terminating beat_done or request drop.
- Gap between back-to-back grants: exactly 2 cycles with gnt_valid=0 (RELEASE, then the IDLE decision cycle).
- Maximum grant length with a continuous request and beat_done every cycle: weight cycles (1 when cfg_arb_scheme=0).
- Starvation bound: any port with a held request is granted within NUM_PORTS-1 intervening grants.

## Structure
- Shared package arb_pkg holds:
  - the state enum (IDLE, GRANT, RELEASE);
  - the NUM_PORTS, PORT_W and WEIGHT_W defaults;
  - the ARB_SCHEME_RR=0 and ARB_SCHEME_WRR=1 constants.
- One combinational sub-module, arb_rr_pick. Inputs: req[NUM_PORTS], base[PORT_W]. Outputs: found, idx[PORT_W]. It implements the rotate-scan-unrotate pick.
- Top level holds the FSM, the credit counter and the priority register.

## Test plan
- After reset, port_req=8'h00 for 5 cycles → gnt_valid=0, high_priority=0, credit=0 throughout.
- cfg_arb_scheme=0, port_req=8'h81 held, beat_done every cycle → grants alternate 0,7,0,7. high_priority goes 1 after each port-0 grant and 0 after each port-7 grant. Each grant is 1 cycle with a 2-cycle gap.
- cfg_arb_scheme=1, weight[3]=4, port_req=8'h08, beat_done every cycle → gnt_port=3 for 4 cycles, credit reads 4,3,2,1; then gnt_valid=0 and high_priority=4.
- cfg_arb_scheme=1, weight[5]=0, port_req=8'h20 → a 1-beat grant (zero weight treated as 1).
- Port 2 granted with weight 6; drop port_req[2] together with the 2nd beat_done → grant ends after that cycle, high_priority=3, next grant goes to the lowest requester ≥3 (with wrap).
- Assert reset during a 5-beat burst after 2 beats → next cycle gnt_valid=0, high_priority=0, credit=0; the next grant starts a full fresh burst.
